// File: rtl/morse_code_keyer.sv
// Timed Morse keyer: accepts ASCII over valid/ready and keys dots, dashes and gaps.
// Optional sidetone output is enabled with `define MORSE_KEYER_SIDETONE_EN.
module morse_code_keyer #(
  parameter int unsigned UNIT_CYCLES      = 50000,
  parameter int unsigned DASH_UNITS       = 3,
  parameter int unsigned LETTER_GAP_UNITS = 3,
  parameter int unsigned WORD_GAP_UNITS   = 7,
  parameter int unsigned CASE_FOLD        = 1
`ifdef MORSE_KEYER_SIDETONE_EN
  ,
  parameter int unsigned TONE_HALF_CYCLES = 250
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy,
  output logic       etx_done,
  output logic       err_invalid
`ifdef MORSE_KEYER_SIDETONE_EN
  ,
  output logic       tone_out
`endif
);

  localparam int unsigned MAXU_A = (DASH_UNITS > LETTER_GAP_UNITS) ? DASH_UNITS : LETTER_GAP_UNITS;
  localparam int unsigned MAXU   = (MAXU_A > WORD_GAP_UNITS) ? MAXU_A : WORD_GAP_UNITS;
  localparam int unsigned CW     = $clog2(MAXU * UNIT_CYCLES + 1);
  localparam int unsigned WORD_PROD = (WORD_GAP_UNITS - LETTER_GAP_UNITS) * UNIT_CYCLES;

  localparam logic [CW-1:0] UNIT_LOAD   = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] DASH_LOAD   = CW'(DASH_UNITS * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] LETTER_LOAD = CW'(LETTER_GAP_UNITS * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] WORD_LOAD   = CW'((WORD_PROD == 0) ? 0 : WORD_PROD - 1);

  typedef enum logic [2:0] {IDLE, MARK, ELEM_GAP, LETTER_GAP, WORD_GAP} state_e;
  typedef enum logic [1:0] {K_SYM, K_SPACE, K_ETX, K_BAD} kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [2:0] len;
    logic [4:0] pat;
  } code_t;

  // Pattern bits are sent from pat[len-1] down to pat[0]; 1 = dash.
  function automatic code_t decode(input logic [7:0] c);
    code_t      r;
    logic [7:0] u;
    r = '{K_BAD, 3'd0, 5'd0};
    u = c;
    if (CASE_FOLD != 0 && c >= 8'h61 && c <= 8'h7A) u = c - 8'h20;
    case (u)
      8'h41: r = '{K_SYM, 3'd2, 5'b00001};
      8'h42: r = '{K_SYM, 3'd4, 5'b01000};
      8'h43: r = '{K_SYM, 3'd4, 5'b01010};
      8'h44: r = '{K_SYM, 3'd3, 5'b00100};
      8'h45: r = '{K_SYM, 3'd1, 5'b00000};
      8'h46: r = '{K_SYM, 3'd4, 5'b00010};
      8'h47: r = '{K_SYM, 3'd3, 5'b00110};
      8'h48: r = '{K_SYM, 3'd4, 5'b00000};
      8'h49: r = '{K_SYM, 3'd2, 5'b00000};
      8'h4A: r = '{K_SYM, 3'd4, 5'b00111};
      8'h4B: r = '{K_SYM, 3'd3, 5'b00101};
      8'h4C: r = '{K_SYM, 3'd4, 5'b00100};
      8'h4D: r = '{K_SYM, 3'd2, 5'b00011};
      8'h4E: r = '{K_SYM, 3'd2, 5'b00010};
      8'h4F: r = '{K_SYM, 3'd3, 5'b00111};
      8'h50: r = '{K_SYM, 3'd4, 5'b00110};
      8'h51: r = '{K_SYM, 3'd4, 5'b01101};
      8'h52: r = '{K_SYM, 3'd3, 5'b00010};
      8'h53: r = '{K_SYM, 3'd3, 5'b00000};
      8'h54: r = '{K_SYM, 3'd1, 5'b00001};
      8'h55: r = '{K_SYM, 3'd3, 5'b00001};
      8'h56: r = '{K_SYM, 3'd4, 5'b00001};
      8'h57: r = '{K_SYM, 3'd3, 5'b00011};
      8'h58: r = '{K_SYM, 3'd4, 5'b01001};
      8'h59: r = '{K_SYM, 3'd4, 5'b01011};
      8'h5A: r = '{K_SYM, 3'd4, 5'b01100};
      8'h30: r = '{K_SYM, 3'd5, 5'b11111};
      8'h31: r = '{K_SYM, 3'd5, 5'b01111};
      8'h32: r = '{K_SYM, 3'd5, 5'b00111};
      8'h33: r = '{K_SYM, 3'd5, 5'b00011};
      8'h34: r = '{K_SYM, 3'd5, 5'b00001};
      8'h35: r = '{K_SYM, 3'd5, 5'b00000};
      8'h36: r = '{K_SYM, 3'd5, 5'b10000};
      8'h37: r = '{K_SYM, 3'd5, 5'b11000};
      8'h38: r = '{K_SYM, 3'd5, 5'b11100};
      8'h39: r = '{K_SYM, 3'd5, 5'b11110};
      8'h20: r = '{K_SPACE, 3'd0, 5'd0};
      8'h03: r = '{K_ETX, 3'd0, 5'd0};
      default: r = '{K_BAD, 3'd0, 5'd0};
    endcase
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [4:0]    pat_q, pat_d;
  logic          etx_q, etx_d;
  logic          err_q, err_d;

  code_t      code;
  logic [2:0] first_idx;
  logic [2:0] next_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      etx_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      etx_q   <= etx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pat_d     = pat_q;
    etx_d     = 1'b0;
    err_d     = 1'b0;
    code      = decode(char_in);
    first_idx = code.len - 3'd1;
    next_idx  = idx_q - 3'd1;
    case (state_q)
      IDLE: begin
        if (char_valid) begin
          case (code.kind)
            K_SYM: begin
              state_d = MARK;
              idx_d   = first_idx;
              pat_d   = code.pat;
              cnt_d   = code.pat[first_idx] ? DASH_LOAD : UNIT_LOAD;
            end
            K_SPACE: begin
              state_d = WORD_GAP;
              cnt_d   = WORD_LOAD;
            end
            K_ETX:   etx_d = 1'b1;
            default: err_d = 1'b1;
          endcase
        end
      end
      MARK: begin
        if (cnt_q == '0) begin
          if (idx_q != 3'd0) begin
            state_d = ELEM_GAP;
            cnt_d   = UNIT_LOAD;
          end else begin
            state_d = LETTER_GAP;
            cnt_d   = LETTER_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ELEM_GAP: begin
        if (cnt_q == '0) begin
          state_d = MARK;
          idx_d   = next_idx;
          cnt_d   = pat_q[next_idx] ? DASH_LOAD : UNIT_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LETTER_GAP, WORD_GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign char_ready  = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign key_out     = (state_q == MARK);
  assign etx_done    = etx_q;
  assign err_invalid = err_q;

`ifdef MORSE_KEYER_SIDETONE_EN
  localparam int unsigned TW = (TONE_HALF_CYCLES > 1) ? $clog2(TONE_HALF_CYCLES) : 1;

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tone_q, tone_d;

  // The tone restarts from 0 at the start of every mark.
  always_comb begin
    tcnt_d = '0;
    tone_d = 1'b0;
    if (key_out) begin
      if (tcnt_q == TW'(TONE_HALF_CYCLES - 1)) begin
        tone_d = ~tone_q;
      end else begin
        tone_d = tone_q;
        tcnt_d = tcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
      tone_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone_out = tone_q & key_out;
`endif

endmodule

// File: tb/tb_morse_code_keyer.sv
// Scoreboard bench: expected per-cycle {key,busy,ready,etx,err} is queued per character.
module tb_morse_code_keyer;
  localparam int unsigned U = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_in     [2];
  logic       char_valid  [2];
  logic       char_ready  [2];
  logic       key_out     [2];
  logic       busy        [2];
  logic       etx_done    [2];
  logic       err_invalid [2];
`ifdef MORSE_KEYER_SIDETONE_EN
  logic       tone_out    [2];
  logic [7:0] t_char_in;
  logic       t_valid, t_ready, t_key, t_busy, t_etx, t_err, t_tone;
`endif

  always #5 clk = ~clk;

  morse_code_keyer #(.UNIT_CYCLES(U), .CASE_FOLD(1)) u_fold (
    .clk(clk), .rst(rst), .char_in(char_in[0]), .char_valid(char_valid[0]),
    .char_ready(char_ready[0]), .key_out(key_out[0]), .busy(busy[0]),
    .etx_done(etx_done[0]), .err_invalid(err_invalid[0])
`ifdef MORSE_KEYER_SIDETONE_EN
    , .tone_out(tone_out[0])
`endif
  );

  morse_code_keyer #(.UNIT_CYCLES(U), .CASE_FOLD(0)) u_nofold (
    .clk(clk), .rst(rst), .char_in(char_in[1]), .char_valid(char_valid[1]),
    .char_ready(char_ready[1]), .key_out(key_out[1]), .busy(busy[1]),
    .etx_done(etx_done[1]), .err_invalid(err_invalid[1])
`ifdef MORSE_KEYER_SIDETONE_EN
    , .tone_out(tone_out[1])
`endif
  );

`ifdef MORSE_KEYER_SIDETONE_EN
  morse_code_keyer #(.UNIT_CYCLES(8), .TONE_HALF_CYCLES(2)) u_tone (
    .clk(clk), .rst(rst), .char_in(t_char_in), .char_valid(t_valid),
    .char_ready(t_ready), .key_out(t_key), .busy(t_busy),
    .etx_done(t_etx), .err_invalid(t_err), .tone_out(t_tone)
  );
`endif

  typedef logic [4:0] obs_t;  // {key, busy, ready, etx, err}

  obs_t       exp_q[$];
  logic [7:0] pend_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic obs_t observe(input int sel);
    return {key_out[sel], busy[sel], char_ready[sel], etx_done[sel], err_invalid[sel]};
  endfunction

  task automatic push_cycles(input int n, input obs_t v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Expected waveform from a dot/dash string, ending on the first ready cycle.
  task automatic model_morse(input string m);
    for (int i = 0; i < m.len(); i++) begin
      push_cycles((m[i] == 8'h2D) ? 3 * U : U, 5'b11000);
      if (i < m.len() - 1) push_cycles(U, 5'b01000);
    end
    push_cycles(3 * U, 5'b01000);
    push_cycles(1, 5'b00100);
  endtask

  task automatic model_space();
    push_cycles((7 - 3) * U, 5'b01000);
    push_cycles(1, 5'b00100);
  endtask

  task automatic model_etx();  push_cycles(1, 5'b00110); endtask
  task automatic model_err();  push_cycles(1, 5'b00101); endtask
  task automatic model_idle(); push_cycles(1, 5'b00100); endtask

  // Presents pending characters (held while not ready) and compares every cycle.
  task automatic run_sb(input int sel, input string tag, input int max_cycles);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < max_cycles) begin
      obs_t e, o;
      if (pend_q.size() > 0) begin
        char_valid[sel] = 1'b1;
        if (char_ready[sel]) char_in[sel] = pend_q.pop_front();
        else                 char_in[sel] = pend_q[0];
      end else begin
        char_valid[sel] = 1'b0;
        char_in[sel]    = 8'($urandom);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = observe(sel);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: {key,busy,ready,etx,err} got %b expected %b", tag, k + 1, o, e);
      end
      k++;
    end
    char_valid[sel] = 1'b0;
    exp_q.delete();
    pend_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (observe(s) !== 5'b00100) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %b expected %b", s, observe(s), 5'b00100);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_letter_e();
    pend_q.push_back(8'h45);
    model_morse(".");
    model_idle();
    run_sb(0, "letter_E", 1000);
  endtask

  task automatic test_letter_a_fold();
    pend_q.push_back(8'h41);
    model_morse(".-");
    model_idle();
    run_sb(0, "letter_A", 1000);
    pend_q.push_back(8'h61);
    model_morse(".-");
    model_idle();
    run_sb(0, "fold_a", 1000);
    pend_q.push_back(8'h61);
    model_err();
    model_idle();
    run_sb(1, "nofold_a", 1000);
  endtask

  task automatic test_space();
    pend_q.push_back(8'h20);
    model_space();
    model_idle();
    run_sb(0, "space", 1000);
  endtask

  task automatic test_etx_invalid();
    pend_q.push_back(8'h03);
    pend_q.push_back(8'h7E);
    model_etx();
    model_err();
    model_idle();
    run_sb(0, "etx_invalid", 1000);
  endtask

  task automatic test_boundaries();
    logic [7:0] bad [6];
    bad = '{8'h40, 8'h5B, 8'h2F, 8'h3A, 8'h60, 8'h7B};
    foreach (bad[i]) begin
      pend_q.push_back(bad[i]);
      model_err();
    end
    model_idle();
    run_sb(0, "range_edges", 1000);
  endtask

  task automatic test_back_to_back();
    pend_q.push_back(8'h45);
    pend_q.push_back(8'h54);
    pend_q.push_back(8'h35);
    pend_q.push_back(8'h7A);
    pend_q.push_back(8'h39);
    pend_q.push_back(8'h51);
    model_morse(".");
    model_morse("-");
    model_morse(".....");
    model_morse("--..");
    model_morse("----.");
    model_morse("--.-");
    model_idle();
    run_sb(0, "back_to_back", 5000);
  endtask

  task automatic test_reset_mid_dash();
    // Third dash of '0' spans cycles 33-44; reset is applied after cycle 38.
    pend_q.push_back(8'h30);
    model_morse("-----");
    run_sb(0, "digit0_pre_reset", 38);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (observe(0) !== 5'b00100) begin
      n_fail++;
      $display("FAIL reset_mid_dash: got %b expected %b", observe(0), 5'b00100);
    end
    pend_q.push_back(8'h54);
    model_morse("-");
    model_idle();
    run_sb(0, "T_after_reset", 1000);
  endtask

`ifdef MORSE_KEYER_SIDETONE_EN
  task automatic test_sidetone();
    logic [1:0] tq[$];  // {key, tone}
    logic [7:0] pat;
    pat = 8'b00110011;
    for (int i = 0; i < 8; i++) tq.push_back({1'b1, pat[7 - i]});
    for (int i = 0; i < 24; i++) tq.push_back(2'b00);
    @(negedge clk);
    t_char_in = 8'h45;
    t_valid   = 1'b1;
    @(posedge clk); #1;
    t_valid   = 1'b0;
    t_char_in = 8'h00;
    for (int c = 1; tq.size() > 0; c++) begin
      logic [1:0] e;
      e = tq.pop_front();
      n_checks++;
      if ({t_key, t_tone} !== e) begin
        n_fail++;
        $display("FAIL sidetone cycle %0d: {key,tone} got %b expected %b", c, {t_key, t_tone}, e);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      char_in[s]    = 8'h00;
      char_valid[s] = 1'b0;
    end
`ifdef MORSE_KEYER_SIDETONE_EN
    t_char_in = 8'h00;
    t_valid   = 1'b0;
`endif
    test_reset();
    test_letter_e();
    test_letter_a_fold();
    test_space();
    test_etx_invalid();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_dash();
`ifdef MORSE_KEYER_SIDETONE_EN
    test_sidetone();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_code_keyer.md
Name: morse_code_keyer

Overview:
- Sequential Morse transmitter in the transceiver path.
- Accepts ASCII characters over a valid/ready handshake and encodes each one internally as a length plus dot/dash pattern.
- Drives a timed on/off key line with standard Morse element and gap timing.
- Successor to the combinational transmit table: adds configurable timing, lowercase folding, word spacing, end-of-text signalling and error flagging.

Parameters:
- UNIT_CYCLES, 50000, clock cycles per Morse time unit (dot length); minimum 1.
- DASH_UNITS, 3, dash length in units.
- LETTER_GAP_UNITS, 3, key-low time after the last element of a character, in units; must be at least 1.
- WORD_GAP_UNITS, 7, total key-low time between words, in units; must be at least LETTER_GAP_UNITS.
- CASE_FOLD, 1, when 1, ASCII 'a'-'z' (0x61-0x7A) are treated as 'A'-'Z'.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- char_in  in  8  ASCII character
- char_valid  in  1  char_in is valid
- char_ready  out  1  keyer can accept a character
- key_out  out  1  key line; 1 = mark (carrier on)
- busy  out  1  high in every state except IDLE
- etx_done  out  1  one-cycle pulse when ETX (0x03) is consumed
- err_invalid  out  1  one-cycle pulse when an unsupported character is consumed

Behaviour:
- Reset values (rst sampled high on a clk edge):
  - state = IDLE, all counters = 0.
  - key_out = 0, busy = 0, etx_done = 0, err_invalid = 0, char_ready = 1.
  - Reset takes priority over every other event, including mid-element: key_out is 0 on the cycle after the edge.
- Handshake:
  - char_ready = (state == IDLE); it is registered-state derived, with no combinational path from char_valid.
  - A transfer occurs on an edge where char_valid && char_ready. char_in is latched at that edge; later changes to char_in are ignored.
- Code table (internal):
  - A-Z and 0-9 use ITU-R M.1677 codes.
  - Each code is stored as length L (1-5) and pattern P[4:0]. Elements are sent from P[L-1] down to P[0]; 1 = dash, 0 = dot.
  - Examples: A = L2/P 01; B = L4/P 1000; 0 = L5/P 11111; 5 = L5/P 00000.
  - Special characters: 0x20 = SPACE, 0x03 = ETX. Every other code is invalid.
- State machine: IDLE, MARK, ELEM_GAP, LETTER_GAP, WORD_GAP.
  - IDLE, valid letter or digit accepted: go to MARK with element index = L-1. key_out = 1 from the next cycle, so latency is 1.
  - MARK: key_out = 1 for UNIT_CYCLES (dot) or DASH_UNITS*UNIT_CYCLES (dash) cycles. At the end, go to ELEM_GAP if index > 0, else LETTER_GAP.
  - ELEM_GAP: key_out = 0 for UNIT_CYCLES cycles, then decrement index and return to MARK.
  - LETTER_GAP: key_out = 0 for LETTER_GAP_UNITS*UNIT_CYCLES cycles, then IDLE.
  - IDLE, SPACE accepted: go to WORD_GAP. key_out stays 0 for (WORD_GAP_UNITS-LETTER_GAP_UNITS)*UNIT_CYCLES cycles, then IDLE. If this product is 0, return to IDLE after 1 cycle.
  - IDLE, ETX accepted: etx_done = 1 on the next cycle only; stay in IDLE; char_ready stays 1.
  - IDLE, invalid character accepted: err_invalid = 1 on the next cycle only; character dropped; stay in IDLE; no key activity.
- Counters and widths:
  - Cycle counter width = clog2(max(DASH_UNITS, LETTER_GAP_UNITS, WORD_GAP_UNITS)*UNIT_CYCLES + 1).
  - It counts down from load-1 to 0 with no wrap. The state changes on the edge where the counter reads 0.
- busy = 1 in MARK, ELEM_GAP, LETTER_GAP and WORD_GAP.
- char_valid held high while not ready: no effect; the character is held off until IDLE.
- Back-to-back characters: the next character is accepted on the first IDLE cycle, so one IDLE cycle separates a letter's gap end from the next mark.

Optional Feature:
- Macro: MORSE_KEYER_SIDETONE_EN.
- When defined:
  - Adds parameter TONE_HALF_CYCLES (default 250) and output port tone_out (1 bit).
  - While key_out = 1, tone_out toggles every TONE_HALF_CYCLES cycles, starting at 0 on the first mark cycle.
  - While key_out = 0 or during reset, tone_out = 0 and the tone counter is cleared.
- When undefined: tone_out, the tone counter and TONE_HALF_CYCLES do not exist; all other behaviour is identical.

Test Plan:
- UNIT_CYCLES=4, defaults; send 'E' (0x45) accepted at cycle 0 -> key_out high cycles 1-4, low cycles 5-16, char_ready high again at cycle 17; busy high cycles 1-16.
- UNIT_CYCLES=4; send 'A' (0x41) at cycle 0 -> key_out high 1-4, low 5-8, high 9-20, low 21-32; ready at 33. Then 'a' (0x61) with CASE_FOLD=1 gives an identical waveform; with CASE_FOLD=0 -> err_invalid pulse, no key.
- UNIT_CYCLES=4; send 0x20 at cycle 0 -> key_out 0 throughout, busy high cycles 1-16, ready at 17.
- Send 0x03 -> etx_done high for exactly one cycle, char_ready never drops. Send 0x7E -> err_invalid one cycle, key_out stays 0.
- UNIT_CYCLES=4; send '0' (0x30), assert rst during the third dash -> key_out=0, busy=0, char_ready=1 on the next cycle; a subsequent 'T' (0x54) -> single 12-cycle mark.
- With MORSE_KEYER_SIDETONE_EN, TONE_HALF_CYCLES=2, UNIT_CYCLES=8; send 'E' -> tone_out pattern 0,0,1,1,0,0,1,1 across the mark, then 0 during the gap.
